// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: control codes, FSM states and the
// alu_ctrl decoder.
package alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic       a_invert;
    logic       b_invert;
    logic [1:0] operation;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [3:0] code);
    ctrl_t d;
    d.a_invert  = code[3];
    d.b_invert  = code[2];
    d.operation = code[1:0];
    case (code)
      CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT, CTRL_NOR: d.illegal = 1'b0;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Operand/result handshake bundle for serial_alu.
interface serial_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       alu_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, src_a, src_b, alu_ctrl, out_ready,
    input  in_ready, out_valid, result, zero, carry_out, overflow
  );

  modport slave (
    input  in_valid, src_a, src_b, alu_ctrl, out_ready,
    output in_ready, out_valid, result, zero, carry_out, overflow
  );
endinterface

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, full adder and
// AND/OR/SUM/LESS select.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic [1:0] operation,
  input  logic       less,
  output logic       bit_result,
  output logic       carry_out,
  output logic       sum
);
  logic a_eff;
  logic b_eff;

  assign a_eff     = a ^ a_invert;
  assign b_eff     = b ^ b_invert;
  assign sum       = a_eff ^ b_eff ^ carry_in;
  assign carry_out = (a_eff & b_eff) | (a_eff & carry_in) | (b_eff & carry_in);

  always_comb begin
    bit_result = 1'b0;
    unique case (operation)
      OP_AND:  bit_result = a_eff & b_eff;
      OP_OR:   bit_result = a_eff | b_eff;
      OP_SUM:  bit_result = sum;
      OP_LESS: bit_result = less;
      default: bit_result = 1'b0;
    endcase
  end
endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: one result bit per clock through a single slice, LSB first,
// with valid/ready handshakes on operands and result.
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst,
  serial_alu_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] res_sr_q, res_sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic             slice_bit;
  logic             slice_carry;
  logic             slice_sum;
  logic [WIDTH-1:0] full_res;
  logic             overflow_raw;
  logic             is_arith;

  alu_bit_slice u_slice (
    .a          (a_sr_q[0]),
    .b          (b_sr_q[0]),
    .carry_in   (carry_q),
    .a_invert   (ctrl_q.a_invert),
    .b_invert   (ctrl_q.b_invert),
    .operation  (ctrl_q.operation),
    .less       (1'b0),
    .bit_result (slice_bit),
    .carry_out  (slice_carry),
    .sum        (slice_sum)
  );

  assign full_res     = {slice_bit, res_sr_q};
  assign overflow_raw = carry_q ^ slice_carry;  // carry into MSB vs out of MSB
  assign is_arith     = (ctrl_q.operation == OP_SUM) && !ctrl_q.illegal;

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    res_sr_d    = res_sr_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    ctrl_d      = ctrl_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sr_d  = bus.src_a;
          b_sr_d  = bus.src_b;
          ctrl_d  = decode_ctrl(bus.alu_ctrl);
          carry_d = ctrl_d.b_invert;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = full_res[WIDTH-1:1];
        carry_d  = slice_carry;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = DONE;
          if (ctrl_q.illegal) begin
            result_d = '0;
          end else if (ctrl_q.operation == OP_LESS) begin
            result_d = {{(WIDTH-1){1'b0}}, slice_sum ^ overflow_raw};
          end else begin
            result_d = full_res;
          end
          zero_d      = !ctrl_q.illegal && (result_d == '0);
          carry_out_d = is_arith & slice_carry;
          overflow_d  = is_arith & overflow_raw;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      res_sr_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      ctrl_q      <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      res_sr_q    <= res_sr_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      ctrl_q      <= ctrl_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Parametrised multi-cycle ALU for the datapath lab.
- Processes two WIDTH-bit operands LSB-first, one bit per clock, through a single 1-bit ALU slice. It keeps a carry flip-flop and shift registers between bits.
- Has a valid/ready handshake on both the operand side and the result side.
- Provides AND, OR, ADD, SUB, SLT and NOR, plus zero, carry and overflow flags. Trades latency for area compared with a ripple array.

Parameters:
- WIDTH, 32: operand/result width in bits; legal range is 2 or more.
- CNT_W, $clog2(WIDTH): width of the bit counter (derived; not overridden).

Ports:
- clk  input  1  sole clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept operands.
- src_a  input  WIDTH  operand A (two's complement for SLT/overflow).
- src_b  input  WIDTH  operand B.
- alu_ctrl  input  4  operation select.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- carry_out  output  1  carry out of the MSB (ADD/SUB only).
- overflow  output  1  signed overflow (ADD/SUB only).

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - Reset rst is asynchronous and active-high.
  - Reset state: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, carry_out=0, overflow=0, counter=0, carry FF=0.
- alu_ctrl encoding (fields are {a_invert, b_invert, operation}):
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT
  - 1100 NOR
  - Any other code is illegal: the op runs normally, but result=0 and all flags=0.
- States:
  - IDLE: in_ready=1.
    - On in_valid & in_ready: latch src_a, src_b and alu_ctrl; carry FF <= b_invert; counter <= 0; go to RUN.
  - RUN: in_ready=0.
    - Each cycle the slice takes operand bit 0 of the shift registers, carry FF and operation, and produces one result bit.
    - The result bit is shifted in at the MSB of the result shift register; operands shift right.
    - Carry FF <= slice carry; counter increments.
    - On the counter == WIDTH-1 cycle, also capture the carry into the MSB and the MSB sum bit; then go to DONE.
    - in_valid is ignored while in RUN.
  - DONE: out_valid=1; result and flags are registered and stable.
    - On out_valid & out_ready: go to IDLE. out_valid drops the next cycle and in_ready rises.
    - No back-to-back overlap: a new accept happens no earlier than the cycle after the result handshake.
- Latency: out_valid is high exactly WIDTH clock edges after the accepting edge. Throughput is one op per WIDTH+2 cycles minimum.
- SLT:
  - The slice computes a-b. less = msb_sum ^ overflow_raw.
  - On entry to DONE: result = {WIDTH-1 zeros, less}; carry_out=0; overflow=0.
- Flags:
  - zero is computed from the final result, including for SLT.
  - carry_out and overflow are valid only for ADD/SUB; they are 0 for every other op.
  - overflow = carry into MSB ^ carry out of MSB.
  - SUB carry_out=1 means no borrow.
- Arithmetic is modulo 2^WIDTH. There are no saturation modes.
- Reset mid-operation returns immediately to the reset state. Any partial result is discarded and never presented.
- Outputs hold their values throughout DONE regardless of input changes.

Decomposition:
- Package alu_pkg:
  - localparams for the six alu_ctrl codes;
  - a state enum (IDLE, RUN, DONE);
  - a function decoding alu_ctrl into {a_invert, b_invert, operation[1:0]} plus an illegal bit.
- Sub-module alu_bit_slice:
  - Purely combinational 1-bit slice: invert, full adder, and 4:1 mux over AND/OR/SUM/LESS, where LESS is tied 0.
  - Outputs: bit_result, carry_out, sum.
  - serial_alu instantiates it once.

Test Plan:
- WIDTH=8, ADD 0x7F+0x01: result=0x80, overflow=1, carry_out=0, zero=0; out_valid rises exactly 8 edges after accept.
- SUB 0x05-0x05: result=0x00, zero=1, carry_out=1, overflow=0. SUB 0x00-0x01: result=0xFF, carry_out=0.
- SLT cases:
  - 0x80,0x7F (-128<127, overflow path) -> result=0x01.
  - 0x7F,0x80 -> 0x00, zero=1.
  - 0x03,0x03 -> 0x00.
- Logic ops:
  - AND 0xF0,0x3C -> 0x30.
  - OR -> 0xFC.
  - NOR 0xF0,0x0F -> 0x00 with zero=1.
  - Illegal code 1111 -> result 0, all flags 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Result and flags stay stable, in_ready=0, and in_valid pulses are not accepted. Release -> IDLE on the following cycle.
- Reset asserted asynchronously mid-RUN (after 3 bits): out_valid=0 and in_ready=1 immediately. The next op (ADD 0x01+0x01) returns 0x02 with no residue from the aborted op.
